// File: rtl/motor_controller.sv
// Two-wheel motor controller: debounced steering command, ramped duty targets,
// glitch-free shadowed PWM and H-bridge direction outputs.
module motor_controller #(
    parameter int unsigned HOLD      = 3,
    parameter int unsigned DUTY_FWD  = 200,
    parameter int unsigned DUTY_FAST = 200,
    parameter int unsigned DUTY_SLOW = 60,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned RAMP_STEP = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [1:0] mode
);

    localparam int unsigned RUN_W = $clog2(HOLD + 1);
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LEFT  = 2'b01,
        ST_RIGHT = 2'b10,
        ST_FWD   = 2'b11
    } ctrl_e;

    ctrl_e             state_q, state_d;
    logic [1:0]        last_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              accept_c;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick_c;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic              wrap_c;
    logic [7:0]        tgt_l_c, tgt_r_c;
    logic [7:0]        cur_l_q, cur_l_d, cur_r_q, cur_r_d;
    logic [7:0]        act_l_q, act_l_d, act_r_q, act_r_d;
    logic              left_pwm_q, right_pwm_q;
    logic [1:0]        dir_q, dir_d;

    // Move a duty one step toward its target, landing exactly on it when close.
    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        ramp = cur;
        if (cur < tgt) begin
            diff = 9'(tgt) - 9'(cur);
            ramp = (diff <= 9'(RAMP_STEP)) ? tgt : cur + 8'(RAMP_STEP);
        end else if (cur > tgt) begin
            diff = 9'(cur) - 9'(tgt);
            ramp = (diff <= 9'(RAMP_STEP)) ? tgt : cur - 8'(RAMP_STEP);
        end
    endfunction

    // Input filter: length of the current run of identical samples, saturating at HOLD.
    always_comb begin
        run_d = run_q;
        if (state != last_q) begin
            run_d = RUN_W'(1);
        end else if (run_q < RUN_W'(HOLD)) begin
            run_d = run_q + RUN_W'(1);
        end
        accept_c = (run_d >= RUN_W'(HOLD));
    end

    // Free-running ramp divider and PWM counter.
    always_comb begin
        tick_c    = (div_q == DIV_W'(RAMP_DIV - 1));
        div_d     = tick_c ? '0 : div_q + DIV_W'(1);
        wrap_c    = (pwm_cnt_q == 8'd254);
        pwm_cnt_d = wrap_c ? 8'd0 : pwm_cnt_q + 8'd1;
    end

    // FSM next state and per-state targets; any state may jump to any other.
    always_comb begin
        state_d = state_q;
        tgt_l_c = 8'd0;
        tgt_r_c = 8'd0;
        dir_d   = 2'b10;
        if (accept_c) begin
            state_d = ctrl_e'(state);
        end
        case (state_d)
            ST_IDLE:  dir_d = 2'b00;
            ST_LEFT:  begin tgt_l_c = 8'(DUTY_SLOW); tgt_r_c = 8'(DUTY_FAST); end
            ST_RIGHT: begin tgt_l_c = 8'(DUTY_FAST); tgt_r_c = 8'(DUTY_SLOW); end
            ST_FWD:   begin tgt_l_c = 8'(DUTY_FWD);  tgt_r_c = 8'(DUTY_FWD);  end
            default:  dir_d = 2'b00;
        endcase
    end

    // Duty ramp and shadowing; entering IDLE zeroes everything at once.
    always_comb begin
        cur_l_d = cur_l_q;
        cur_r_d = cur_r_q;
        act_l_d = act_l_q;
        act_r_d = act_r_q;
        if (state_d == ST_IDLE) begin
            cur_l_d = 8'd0;
            cur_r_d = 8'd0;
            act_l_d = 8'd0;
            act_r_d = 8'd0;
        end else begin
            if (wrap_c) begin
                act_l_d = cur_l_q;
                act_r_d = cur_r_q;
            end
            if (tick_c) begin
                cur_l_d = ramp(cur_l_q, tgt_l_c);
                cur_r_d = ramp(cur_r_q, tgt_r_c);
            end
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 2'b00;
            run_q       <= '0;
            div_q       <= '0;
            pwm_cnt_q   <= 8'd0;
            cur_l_q     <= 8'd0;
            cur_r_q     <= 8'd0;
            act_l_q     <= 8'd0;
            act_r_q     <= 8'd0;
            left_pwm_q  <= 1'b0;
            right_pwm_q <= 1'b0;
            dir_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= state;
            run_q       <= run_d;
            div_q       <= div_d;
            pwm_cnt_q   <= pwm_cnt_d;
            cur_l_q     <= cur_l_d;
            cur_r_q     <= cur_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            left_pwm_q  <= (pwm_cnt_q < act_l_q);
            right_pwm_q <= (pwm_cnt_q < act_r_q);
            dir_q       <= dir_d;
        end
    end

    assign mode      = state_q;
    assign left_pwm  = left_pwm_q;
    assign right_pwm = right_pwm_q;
    assign left_dir  = dir_q;
    assign right_dir = dir_q;

endmodule

// File: tb/tb_motor_controller.sv
// Self-checking bench for motor_controller: vector table, directed corner
// sequences and randomized commands against a time-indexed reference model.
module tb_motor_controller;

    localparam int HOLD  = 3;
    localparam int RDIV  = 4;
    localparam int RSTEP = 50;
    localparam int DFWD  = 200;
    localparam int DFAST = 200;
    localparam int DSLOW = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state;
    logic       left_pwm, right_pwm;
    logic [1:0] left_dir, right_dir, mode;

    always #5 clk = ~clk;

    motor_controller #(
        .HOLD(HOLD), .DUTY_FWD(DFWD), .DUTY_FAST(DFAST), .DUTY_SLOW(DSLOW),
        .RAMP_DIV(RDIV), .RAMP_STEP(RSTEP)
    ) dut (
        .clk(clk), .reset(reset), .state(state),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir), .mode(mode)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: everything derived from the edge count since reset.
    int         m_n;
    logic [1:0] m_hist[$];
    int         m_mode, m_cur_l, m_cur_r, m_act_l, m_act_r;
    int         m_pwm_l, m_pwm_r;

    typedef struct {
        logic [1:0] st;
        int         cycles;
        logic [1:0] exp_mode;
        logic [1:0] exp_dir;
    } vec_t;
    vec_t tbl[11];

    function automatic int approach(int c, int t);
        if (c < t) return (t - c <= RSTEP) ? t : c + RSTEP;
        if (c > t) return (c - t <= RSTEP) ? t : c - RSTEP;
        return c;
    endfunction

    function automatic int tgt_l(int m);
        case (m)
            1: return DSLOW;
            2: return DFAST;
            3: return DFWD;
            default: return 0;
        endcase
    endfunction

    function automatic int tgt_r(int m);
        case (m)
            1: return DFAST;
            2: return DSLOW;
            3: return DFWD;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_hist.delete();
        m_mode = 0; m_cur_l = 0; m_cur_r = 0; m_act_l = 0; m_act_r = 0;
        m_pwm_l = 0; m_pwm_r = 0;
    endtask

    task automatic model_step();
        bit same;
        m_n++;
        m_hist.push_back(state);
        if (m_hist.size() > HOLD) void'(m_hist.pop_front());
        if (m_hist.size() == HOLD) begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
            if (same) m_mode = int'(m_hist[0]);
        end
        m_pwm_l = (((m_n - 1) % 255) < m_act_l) ? 1 : 0;
        m_pwm_r = (((m_n - 1) % 255) < m_act_r) ? 1 : 0;
        if (m_mode == 0) begin
            m_cur_l = 0; m_cur_r = 0; m_act_l = 0; m_act_r = 0;
        end else begin
            if (m_n % 255 == 0) begin
                m_act_l = m_cur_l;
                m_act_r = m_cur_r;
            end
            if (m_n % RDIV == 0) begin
                m_cur_l = approach(m_cur_l, tgt_l(m_mode));
                m_cur_r = approach(m_cur_r, tgt_r(m_mode));
            end
        end
    endtask

    task automatic compare_all();
        int exp_dir;
        exp_dir = (m_mode != 0) ? 2 : 0;
        check("mode", mode, m_mode);
        check("left_dir", left_dir, exp_dir);
        check("right_dir", right_dir, exp_dir);
        check("left_pwm", left_pwm, m_pwm_l);
        check("right_pwm", right_pwm, m_pwm_r);
        check("cur_l", dut.cur_l_q, m_cur_l);
        check("cur_r", dut.cur_r_q, m_cur_r);
    endtask

    // One clock: model advances on the rising edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        state = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_lpwm", left_pwm, 0);
        check("rst_rpwm", right_pwm, 0);
        check("rst_ldir", left_dir, 0);
        check("rst_rdir", right_dir, 0);
        check("rst_pwmcnt", dut.pwm_cnt_q, 0);
        reset = 1'b1;
    endtask

    task automatic count_high(output int hl, output int hr);
        hl = 0;
        hr = 0;
        repeat (255) begin
            cyc();
            hl += int'(left_pwm);
            hr += int'(right_pwm);
        end
    endtask

    initial begin
        int hl, hr, k;

        tbl[0]  = '{2'b11, 2, 2'b00, 2'b00};
        tbl[1]  = '{2'b11, 1, 2'b11, 2'b10};
        tbl[2]  = '{2'b01, 2, 2'b11, 2'b10};
        tbl[3]  = '{2'b11, 3, 2'b11, 2'b10};
        tbl[4]  = '{2'b01, 3, 2'b01, 2'b10};
        tbl[5]  = '{2'b10, 3, 2'b10, 2'b10};
        tbl[6]  = '{2'b00, 2, 2'b10, 2'b10};
        tbl[7]  = '{2'b00, 1, 2'b00, 2'b00};
        tbl[8]  = '{2'b10, 3, 2'b10, 2'b10};
        tbl[9]  = '{2'b11, 3, 2'b11, 2'b10};
        tbl[10] = '{2'b00, 3, 2'b00, 2'b00};

        reset = 1'b0;
        state = 2'b00;
        model_reset();

        // Filter latency, rejection and direction table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            state = tbl[i].st;
            repeat (tbl[i].cycles) cyc();
            check("tbl_mode", mode, tbl[i].exp_mode);
            check("tbl_ldir", left_dir, tbl[i].exp_dir);
            check("tbl_rdir", right_dir, tbl[i].exp_dir);
        end

        // Forward from reset settles at 200/255 on both wheels.
        do_reset();
        state = 2'b11;
        repeat (600) cyc();
        count_high(hl, hr);
        check("fwd_left_high", hl, 200);
        check("fwd_right_high", hr, 200);

        // Short left glitch is ignored.
        state = 2'b01;
        repeat (2) cyc();
        state = 2'b11;
        repeat (10) cyc();
        check("glitch_mode", mode, 3);
        check("glitch_cur_l", dut.cur_l_q, 200);

        // Left turn: inner wheel clamps at 60, outer stays 200.
        state = 2'b01;
        repeat (600) cyc();
        count_high(hl, hr);
        check("left_left_high", hl, 60);
        check("left_right_high", hr, 200);

        // Stop: PWM low one clock after the mode change.
        state = 2'b11;
        repeat (600) cyc();
        state = 2'b00;
        k = 0;
        while (mode != 2'b00 && k < 10) begin
            cyc();
            k++;
        end
        check("stop_mode", mode, 0);
        cyc();
        check("stop_lpwm", left_pwm, 0);
        check("stop_rpwm", right_pwm, 0);
        check("stop_ldir", left_dir, 0);
        check("stop_act_l", dut.act_l_q, 0);

        // Asynchronous reset mid-ramp, then restart from zero.
        do_reset();
        state = 2'b11;
        k = 0;
        while (m_cur_l != 100 && k < 100) begin
            cyc();
            k++;
        end
        check("midramp_cur_l", dut.cur_l_q, 100);
        #2 reset = 1'b0;
        #1;
        check("async_mode", mode, 0);
        check("async_lpwm", left_pwm, 0);
        check("async_rpwm", right_pwm, 0);
        check("async_ldir", left_dir, 0);
        check("async_rdir", right_dir, 0);
        check("async_cur_l", dut.cur_l_q, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) cyc();

        // Mode change to RIGHT landing on a ramp tick steps toward the new target.
        repeat (600) cyc();
        while ((m_n + 3) % RDIV != 0) cyc();
        state = 2'b10;
        repeat (3) cyc();
        check("tick_mode", mode, 2);
        check("tick_cur_r", dut.cur_r_q, 150);
        check("tick_cur_l", dut.cur_l_q, 200);
        k = 0;
        while (m_n % 255 != 0 && k < 300) begin
            cyc();
            k++;
        end
        check("tick_act_l", dut.act_l_q, 200);

        // Randomized commands with random hold lengths.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            state = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 8)) cyc();
            if (i % 50 == 0) repeat (300) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_controller.md
MOTOR_CONTROLLER -- requirements
Module: motor_controller

Interface
REQ-001 Parameter HOLD, default 3: number of consecutive equal samples of state before a new command is accepted.
REQ-002 Parameter DUTY_FWD, default 200: target duty for both wheels in forward.
REQ-003 Parameter DUTY_FAST, default 200: target duty for the outer wheel in a turn.
REQ-004 Parameter DUTY_SLOW, default 60: target duty for the inner wheel in a turn.
REQ-005 Parameter RAMP_DIV, default 1000: clock cycles between ramp ticks.
REQ-006 Parameter RAMP_STEP, default 20: maximum duty change per ramp tick.
REQ-007 Port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-low reset; 0 resets the block immediately.
REQ-009 Port state, input, 2 bits: steering command from the line sensor; 00 stop, 01 left, 10 right, 11 forward.
REQ-010 Port left_pwm, output, 1 bit: PWM enable for the left motor.
REQ-011 Port right_pwm, output, 1 bit: PWM enable for the right motor.
REQ-012 Port left_dir, output, 2 bits: H-bridge IN1/IN2 for the left motor; 10 forward, 00 coast.
REQ-013 Port right_dir, output, 2 bits: H-bridge IN1/IN2 for the right motor; 10 forward, 00 coast.
REQ-014 Port mode, output, 2 bits: accepted command, using the same encoding as state.

Function
REQ-015 Input filter: mode SHALL take a new state value only after state has held that value for HOLD consecutive edges.
REQ-016 Filter latency: mode SHALL update no earlier than HOLD and no later than HOLD+1 cycles after the input changes.
REQ-017 Filter reject: a state value lasting fewer than HOLD cycles SHALL leave mode unchanged.
REQ-018 FSM states: IDLE (mode 00), LEFT (01), RIGHT (10), FWD (11); the state equals the mode value, and any state can go directly to any other.
REQ-019 Target duties (left, right): IDLE (0, 0); FWD (DUTY_FWD, DUTY_FWD); LEFT (DUTY_SLOW, DUTY_FAST); RIGHT (DUTY_FAST, DUTY_SLOW).
REQ-020 Ramp tick counter: free-running from 0 to RAMP_DIV-1, wrapping to 0; a tick occurs on the wrap.
REQ-021 Ramp step: on each tick, each current duty (8-bit) SHALL move toward its target by RAMP_STEP.
REQ-022 Ramp clamp: a duty within RAMP_STEP of its target SHALL be set to the target exactly; no overshoot and no 8-bit wrap.
REQ-023 Stop override: on entry to IDLE, both current duties SHALL be 0 on the next clock, bypassing the ramp.
REQ-024 PWM counter: free-running from 0 to 254, wrapping to 0, giving a period of 255 cycles.
REQ-025 Duty shadowing: the current duties SHALL be copied into active duties only on the 254->0 wrap, so no PWM period is glitched mid-cycle.
REQ-026 PWM output: x_pwm SHALL be registered (pwm_cnt < active_duty_x); duty 0 gives a constant low, duty 255 a constant high.
REQ-027 Stop exception: after entry to IDLE, the active duties SHALL be forced to 0 in the same cycle as the current duties, without waiting for the wrap.
REQ-028 Direction: x_dir SHALL be 10 when mode is not IDLE, and 00 in IDLE.
REQ-029 Simultaneous events: if a ramp tick and a mode change fall on the same edge, the step SHALL be taken toward the new target.
REQ-030 Direction limit: the block SHALL never drive the reverse (01) or brake (11) patterns on x_dir.

Reset
REQ-031 While reset=0: mode=00, both duties=0, all counters=0, left_pwm=right_pwm=0, left_dir=right_dir=00.
REQ-032 Reset asserted mid-ramp or mid-PWM period SHALL clear all outputs asynchronously.
REQ-033 After release, the filter SHALL require a full HOLD-cycle run before mode leaves 00.

Verification
Bench parameters: HOLD=3, RAMP_DIV=4, RAMP_STEP=50, DUTY_FWD=200, DUTY_FAST=200, DUTY_SLOW=60.
REQ-034 Scenario 1: reset release, state=11 held -> mode=11 within 4 cycles; dir=10/10; current duties 0->50->100->150->200 on successive ticks; left_pwm high for 200 of every 255 cycles once settled.
REQ-035 Scenario 2: state=11 settled, then a 2-cycle pulse of 01 -> mode stays 11; duties unchanged.
REQ-036 Scenario 3: FWD settled, then state=01 held -> mode=01; left duty 200->150->100->60 (clamped); right duty stays 200.
REQ-037 Scenario 4: FWD settled, then state=00 held -> mode=00; both PWM outputs low on the next clock after the mode change; dir=00/00.
REQ-038 Scenario 5: reset driven low mid-ramp at duty 100, between clock edges -> all outputs 0 immediately; after release the ramp restarts from 0.
REQ-039 Scenario 6: state changes to 10 on the cycle of a ramp tick -> the step is taken toward right=60 and left=200; the duty change appears only after the next PWM wrap.
